fetcher: RTL and testbench

//   Per-core instruction fetch stage, upstream of decode and consuming the PC from the pc unit.
//   - When the core scheduler enters FETCH, issues one read of program memory at current_pc.
//   - Runs the valid/ready handshake with the program-memory controller.
//   - Holds the returned instruction stable for the decoder until the core enters DECODE.

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/fetcher_if.sv | 32 +++
 rtl/fetch_line_cache.sv | 45 ++++
 rtl/fetcher.sv | 136 +++++++++++++
 tb/tb_fetcher.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared encodings and default widths for the GPU core slice:
//                core scheduler states, fetcher states, program-memory widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    // Default program-memory geometry
    localparam int unsigned PROGRAM_MEM_ADDR_BITS_DEFAULT = 8;
    localparam int unsigned PROGRAM_MEM_DATA_BITS_DEFAULT = 16;

    // Core scheduler states
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_e;

    // Fetcher state encodings; every other 3-bit value is illegal
    localparam logic [2:0] FETCHER_IDLE     = 3'b000;
    localparam logic [2:0] FETCHER_FETCHING = 3'b001;
    localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetcher_if
//  Description : Program-memory read channel between a fetcher (master) and
//                the program-memory controller (slave). Valid/ready handshake;
//                read data is valid in the same cycle as ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetcher_if #(
    parameter int ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS_DEFAULT,
    parameter int DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS_DEFAULT
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_line_cache.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_line_cache
//  Description : One-entry tagged instruction line. Filled on every completed
//                memory fetch, invalidated only by reset. Lookup is purely
//                combinational against the stored tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_cache #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [ADDR_BITS-1:0] lookup_addr,
    output logic                      hit,
    output logic [DATA_BITS-1:0]      hit_data,
    input  wire logic                 fill_en,
    input  wire logic [ADDR_BITS-1:0] fill_addr,
    input  wire logic [DATA_BITS-1:0] fill_data
);
    logic                 valid_q;
    logic [ADDR_BITS-1:0] tag_q;
    logic [DATA_BITS-1:0] data_q;

    // Line storage: cleared by reset, overwritten by each completed fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr;
            data_q  <= fill_data;
        end
    end

    // Tag compare
    always_comb begin
        hit      = valid_q && (tag_q == lookup_addr);
        hit_data = data_q;
    end
endmodule
`default_nettype wire

// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : fetcher
//  Description : Per-core instruction fetch stage. On core FETCH issues one
//                program-memory read at current_pc, completes the valid/ready
//                handshake and holds the instruction until core DECODE.
//                Optional feature macro: FETCHER_LINE_CACHE_EN adds a
//                one-entry instruction line that short-circuits repeat fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT,
    parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEFAULT
) (
    input  wire logic                             clk,
    input  wire logic                             reset,
    input  wire logic [2:0]                       core_state,
    input  wire logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    fetcher_if.master                             mem,
    output logic [2:0]                            fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0]      instruction
);
    localparam int A = PROGRAM_MEM_ADDR_BITS;
    localparam int D = PROGRAM_MEM_DATA_BITS;

    logic [2:0]   state_q, state_d;
    logic         valid_q, valid_d;
    logic [A-1:0] addr_q,  addr_d;
    logic [D-1:0] instr_q, instr_d;

    logic         line_hit;
    logic [D-1:0] line_data;

    logic fetch_req;
    logic decode_req;
    assign fetch_req  = (core_state == CORE_FETCH);
    assign decode_req = (core_state == CORE_DECODE);

`ifdef FETCHER_LINE_CACHE_EN
    logic line_fill;
    // A fill happens exactly when the memory handshake completes
    assign line_fill = (state_q == FETCHER_FETCHING) && mem.mem_read_ready;

    fetch_line_cache #(
        .ADDR_BITS (A),
        .DATA_BITS (D)
    ) u_line (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (current_pc),
        .hit         (line_hit),
        .hit_data    (line_data),
        .fill_en     (line_fill),
        .fill_addr   (addr_q),
        .fill_data   (mem.mem_read_data)
    );
`else
    assign line_hit  = 1'b0;
    assign line_data = '0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCHER_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic; illegal encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCHER_IDLE: begin
                if (fetch_req) begin
                    state_d = line_hit ? FETCHER_FETCHED : FETCHER_FETCHING;
                end
            end
            FETCHER_FETCHING: begin
                // The handshake always completes regardless of core_state
                if (mem.mem_read_ready) begin
                    state_d = FETCHER_FETCHED;
                end
            end
            FETCHER_FETCHED: begin
                if (decode_req) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: state_d = FETCHER_IDLE;
        endcase
    end

    // Request, address capture and instruction latch
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            FETCHER_IDLE: begin
                if (fetch_req) begin
                    if (line_hit) begin
                        instr_d = line_data;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                    end
                end
            end
            FETCHER_FETCHING: begin
                if (mem.mem_read_ready) begin
                    instr_d = mem.mem_read_data;
                    valid_d = 1'b0;
                end
            end
            FETCHER_FETCHED: begin
            end
            default: valid_d = 1'b0;
        endcase
    end

    assign mem.mem_read_valid   = valid_q;
    assign mem.mem_read_address = addr_q;
    assign fetcher_state        = state_q;
    assign instruction          = instr_q;
endmodule
`default_nettype wire

// File: tb/tb_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetcher
//  Description : Self-checking bench for fetcher: per-cycle vector table plus
//                a hand-written repeat-fetch sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetcher;
    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;
    localparam logic [2:0] CS_WAIT   = 3'b100;
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_FING   = 3'b001;
    localparam logic [2:0] ST_FED    = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int errors = 0;
    int checks = 0;

    fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

    fetcher #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .mem           (bus.master),
        .fetcher_state (fetcher_state),
        .instruction   (instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  cs;
        logic [7:0]  pc;
        logic        rdy;
        logic [15:0] data;
        logic        e_valid;
        logic [7:0]  e_addr;
        logic [2:0]  e_state;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic rst, logic [2:0] cs, logic [7:0] pc, logic rdy,
                                logic [15:0] data, logic ev, logic [7:0] ea,
                                logic [2:0] es, logic [15:0] ei);
        vec_t v;
        v.rst = rst; v.cs = cs; v.pc = pc; v.rdy = rdy; v.data = data;
        v.e_valid = ev; v.e_addr = ea; v.e_state = es; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge
    task automatic step(input logic rst, input logic [2:0] cs, input logic [7:0] pc,
                        input logic rdy, input logic [15:0] data);
        @(negedge clk);
        reset              = rst;
        core_state         = cs;
        current_pc         = pc;
        bus.mem_read_ready = rdy;
        bus.mem_read_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic ev, input logic [7:0] ea,
                              input logic [2:0] es, input logic [15:0] ei);
        chk({tag, ".valid"}, 32'(bus.mem_read_valid),   32'(ev));
        chk({tag, ".addr"},  32'(bus.mem_read_address), 32'(ea));
        chk({tag, ".state"}, 32'(fetcher_state),        32'(es));
        chk({tag, ".instr"}, 32'(instruction),          32'(ei));
    endtask

    initial begin
        reset = 1'b1; core_state = CS_FETCH; current_pc = 8'h00;
        bus.mem_read_ready = 1'b0; bus.mem_read_data = 16'h0000;

        //                rst cs         pc     rdy  data      valid addr   state    instr
        vecs[0]  = mk(1, CS_FETCH,  8'h00, 0, 16'h0000, 0, 8'h00, ST_IDLE, 16'h0000);
        vecs[1]  = mk(1, CS_FETCH,  8'h00, 0, 16'h0000, 0, 8'h00, ST_IDLE, 16'h0000);
        vecs[2]  = mk(0, CS_FETCH,  8'h05, 0, 16'h0000, 1, 8'h05, ST_FING, 16'h0000);
        vecs[3]  = mk(0, CS_WAIT,   8'h09, 0, 16'h1111, 1, 8'h05, ST_FING, 16'h0000);
        vecs[4]  = mk(0, CS_WAIT,   8'h09, 0, 16'h2222, 1, 8'h05, ST_FING, 16'h0000);
        vecs[5]  = mk(0, CS_WAIT,   8'h09, 1, 16'h3A21, 0, 8'h05, ST_FED,  16'h3A21);
        vecs[6]  = mk(0, CS_FETCH,  8'h09, 0, 16'h0000, 0, 8'h05, ST_FED,  16'h3A21);
        vecs[7]  = mk(0, CS_FETCH,  8'h09, 0, 16'h0000, 0, 8'h05, ST_FED,  16'h3A21);
        vecs[8]  = mk(0, CS_FETCH,  8'h09, 1, 16'h7777, 0, 8'h05, ST_FED,  16'h3A21);
        vecs[9]  = mk(0, CS_FETCH,  8'h09, 0, 16'h0000, 0, 8'h05, ST_FED,  16'h3A21);
        vecs[10] = mk(0, CS_DECODE, 8'h09, 0, 16'h0000, 0, 8'h05, ST_IDLE, 16'h3A21);
        vecs[11] = mk(0, CS_WAIT,   8'h09, 1, 16'hFFFF, 0, 8'h05, ST_IDLE, 16'h3A21);
        vecs[12] = mk(0, CS_FETCH,  8'hFF, 0, 16'h0000, 1, 8'hFF, ST_FING, 16'h3A21);
        vecs[13] = mk(0, CS_WAIT,   8'h00, 1, 16'hBEEF, 0, 8'hFF, ST_FED,  16'hBEEF);
        vecs[14] = mk(0, CS_DECODE, 8'h00, 0, 16'h0000, 0, 8'hFF, ST_IDLE, 16'hBEEF);
        vecs[15] = mk(0, CS_FETCH,  8'h07, 0, 16'h0000, 1, 8'h07, ST_FING, 16'hBEEF);
        vecs[16] = mk(1, CS_WAIT,   8'h07, 0, 16'h0000, 0, 8'h00, ST_IDLE, 16'h0000);
        vecs[17] = mk(0, CS_WAIT,   8'h07, 1, 16'h1234, 0, 8'h00, ST_IDLE, 16'h0000);
        vecs[18] = mk(0, CS_WAIT,   8'h07, 1, 16'h1234, 0, 8'h00, ST_IDLE, 16'h0000);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].cs, vecs[i].pc, vecs[i].rdy, vecs[i].data);
            expect_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr,
                       vecs[i].e_state, vecs[i].e_instr);
        end

        // Repeat fetch of the same PC, then a neighbouring PC
        step(0, CS_FETCH,  8'h10, 0, 16'h0000);
        expect_all("rf.req1", 1, 8'h10, ST_FING, 16'h0000);
        step(0, CS_WAIT,   8'h10, 1, 16'hABCD);
        expect_all("rf.ack1", 0, 8'h10, ST_FED, 16'hABCD);
        step(0, CS_DECODE, 8'h10, 0, 16'h0000);
        expect_all("rf.dec1", 0, 8'h10, ST_IDLE, 16'hABCD);
        step(0, CS_FETCH,  8'h10, 0, 16'h0000);
`ifdef FETCHER_LINE_CACHE_EN
        expect_all("rf.hit", 0, 8'h10, ST_FED, 16'hABCD);
`else
        expect_all("rf.req2", 1, 8'h10, ST_FING, 16'hABCD);
        step(0, CS_WAIT,   8'h10, 1, 16'hABCD);
        expect_all("rf.ack2", 0, 8'h10, ST_FED, 16'hABCD);
`endif
        step(0, CS_DECODE, 8'h10, 0, 16'h0000);
        expect_all("rf.dec2", 0, 8'h10, ST_IDLE, 16'hABCD);
        step(0, CS_FETCH,  8'h11, 0, 16'h0000);
        expect_all("rf.miss", 1, 8'h11, ST_FING, 16'hABCD);
        step(0, CS_WAIT,   8'h11, 1, 16'h5555);
        expect_all("rf.ack3", 0, 8'h11, ST_FED, 16'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
